// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the decode hazard check and the arbiter.
// The master drives requests and read addresses; the slave (arbiter) drives grants and the write port.
interface reg_wb_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic          aValid;
  logic [AW-1:0] aAddr;
  logic [DW-1:0] aData;
  logic          aReady;
  logic          bValid;
  logic [AW-1:0] bAddr;
  logic [DW-1:0] bData;
  logic          bReady;
  logic          wbHold;
  logic          wEna;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wDin;
  logic [AW-1:0] rAddr1;
  logic [AW-1:0] rAddr2;
  logic          hazard1;
  logic          hazard2;

  modport master (
    output aValid, aAddr, aData, bValid, bAddr, bData, wbHold, rAddr1, rAddr2,
    input  aReady, bReady, wEna, wAddr, wDin, hazard1, hazard2
  );

  modport slave (
    input  aValid, aAddr, aData, bValid, bAddr, bData, wbHold, rAddr1, rAddr2,
    output aReady, bReady, wEna, wAddr, wDin, hazard1, hazard2
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A) and load (B)
// writeback paths, with a registered write port and read-after-write hazard flags for decode.
module reg_wb_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input logic            clk,
  input logic            rst_n,
  reg_wb_arbiter_if.slave bus
);

  typedef enum logic {PrioA, PrioB} prio_e;

  prio_e         prio_q, prio_d;
  logic          a_grant, b_grant;
  logic          w_ena_q, w_ena_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [DW-1:0] w_din_q, w_din_d;

  // State register: priority pointer and the single output write stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q   <= PrioA;
      w_ena_q  <= 1'b0;
      w_addr_q <= '0;
      w_din_q  <= '0;
    end else begin
      prio_q   <= prio_d;
      w_ena_q  <= w_ena_d;
      w_addr_q <= w_addr_d;
      w_din_q  <= w_din_d;
    end
  end

  // Grant decode; readies must stay low while reset is asserted, even between edges.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (rst_n && !bus.wbHold) begin
      if (bus.aValid && (!bus.bValid || prio_q == PrioA)) begin
        a_grant = 1'b1;
      end else if (bus.bValid) begin
        b_grant = 1'b1;
      end
    end
  end

  // Next state: pointer moves to the loser of each accepted transfer.
  always_comb begin
    prio_d   = prio_q;
    w_ena_d  = 1'b0;
    w_addr_d = w_addr_q;
    w_din_d  = w_din_q;
    if (a_grant) begin
      prio_d   = PrioB;
      w_ena_d  = (bus.aAddr != '0);
      w_addr_d = bus.aAddr;
      w_din_d  = bus.aData;
    end else if (b_grant) begin
      prio_d   = PrioA;
      w_ena_d  = (bus.bAddr != '0);
      w_addr_d = bus.bAddr;
      w_din_d  = bus.bData;
    end
  end

  // Outputs
  always_comb begin
    bus.aReady = a_grant;
    bus.bReady = b_grant;
    bus.wEna   = w_ena_q;
    bus.wAddr  = w_addr_q;
    bus.wDin   = w_din_q;
    bus.hazard1 = (bus.rAddr1 != '0) &&
                  ((w_ena_q && w_addr_q == bus.rAddr1) ||
                   (bus.aValid && bus.aAddr == bus.rAddr1) ||
                   (bus.bValid && bus.bAddr == bus.rAddr1));
    bus.hazard2 = (bus.rAddr2 != '0) &&
                  ((w_ena_q && w_addr_q == bus.rAddr2) ||
                   (bus.aValid && bus.aAddr == bus.rAddr2) ||
                   (bus.bValid && bus.bAddr == bus.rAddr2));
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: hand-computed vector table, randomized traffic against a
// turn-based reference model, and an asynchronous reset landing on a live write.
module tb_reg_wb_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  reg_wb_arbiter_if #(.DW(32), .AW(5)) bus ();

  reg_wb_arbiter #(.DW(32), .AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        hold;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        ea;
    logic        eb;
    logic        eh1;
    logic        eh2;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
  } vec_t;

  vec_t tbl[$];

  // Reference model: whose turn it is on a tie, and the write sitting on the port.
  bit          m_b_turn;
  bit          m_wena;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdin;
  logic [31:0] mdl_rf[32];
  logic [31:0] dut_rf[32];
  int          last_w;

  always @(posedge clk) if (bus.wEna) dut_rf[bus.wAddr] <= bus.wDin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic row(input int av, aa, ad, bv, ba, bd, hold, r1, r2,
                     input int ea, eb, eh1, eh2, ewe, ewa, ewd);
    vec_t v;
    v.av = av[0];  v.aa = aa[4:0];  v.ad = 32'(ad);
    v.bv = bv[0];  v.ba = ba[4:0];  v.bd = 32'(bd);
    v.hold = hold[0];  v.r1 = r1[4:0];  v.r2 = r2[4:0];
    v.ea = ea[0];  v.eb = eb[0];  v.eh1 = eh1[0];  v.eh2 = eh2[0];
    v.ewe = ewe[0];  v.ewa = ewa[4:0];  v.ewd = 32'(ewd);
    tbl.push_back(v);
  endtask

  // -1: nobody, 0: A, 1: B
  function automatic int winner();
    if (!rst_n || bus.wbHold) return -1;
    if (bus.aValid && bus.bValid) return m_b_turn ? 1 : 0;
    if (bus.aValid) return 0;
    if (bus.bValid) return 1;
    return -1;
  endfunction

  function automatic logic m_haz(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return (m_wena && m_waddr == r) || (bus.aValid && bus.aAddr == r) ||
           (bus.bValid && bus.bAddr == r);
  endfunction

  task automatic model_reset();
    m_b_turn = 1'b0;
    m_wena   = 1'b0;
    m_waddr  = '0;
    m_wdin   = '0;
  endtask

  task automatic check_model(input string tag);
    int w;
    w = winner();
    chk({tag, ".aReady"}, 32'(bus.aReady), 32'(w == 0));
    chk({tag, ".bReady"}, 32'(bus.bReady), 32'(w == 1));
    chk({tag, ".hazard1"}, 32'(bus.hazard1), 32'(m_haz(bus.rAddr1)));
    chk({tag, ".hazard2"}, 32'(bus.hazard2), 32'(m_haz(bus.rAddr2)));
    chk({tag, ".wEna"}, 32'(bus.wEna), 32'(m_wena));
    chk({tag, ".wAddr"}, 32'(bus.wAddr), 32'(m_waddr));
    chk({tag, ".wDin"}, bus.wDin, m_wdin);
  endtask

  // Step the model across the next rising edge using the inputs it sees there.
  task automatic advance();
    int w;
    @(posedge clk);
    w = winner();
    last_w = w;
    if (m_wena) mdl_rf[m_waddr] = m_wdin;
    if (w == 0) begin
      m_waddr = bus.aAddr;  m_wdin = bus.aData;  m_wena = (bus.aAddr != 0);  m_b_turn = 1'b1;
    end else if (w == 1) begin
      m_waddr = bus.bAddr;  m_wdin = bus.bData;  m_wena = (bus.bAddr != 0);  m_b_turn = 1'b0;
    end else begin
      m_wena = 1'b0;
    end
    #1;
  endtask

  task automatic drive_idle();
    bus.aValid = 1'b0;  bus.aAddr = '0;  bus.aData = '0;
    bus.bValid = 1'b0;  bus.bAddr = '0;  bus.bData = '0;
    bus.wbHold = 1'b0;  bus.rAddr1 = '0;  bus.rAddr2 = '0;
  endtask

  initial begin
    int bad;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) begin
      mdl_rf[i] = '0;
      dut_rf[i] = '0;
    end
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #1;
    chk("rst.wEna", 32'(bus.wEna), 32'd0);
    chk("rst.wAddr", 32'(bus.wAddr), 32'd0);
    chk("rst.wDin", bus.wDin, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // av aa ad  bv ba bd  hold r1 r2 | aR bR h1 h2  wEna wAddr wDin (seen this cycle)
    row(0, 0, 0,       0, 0, 0,        0, 0, 0,  0, 0, 0, 0,  0, 0, 0);
    row(1, 5, 'h1234,  0, 0, 0,        0, 5, 0,  1, 0, 1, 0,  0, 0, 0);
    row(0, 0, 0,       0, 0, 0,        0, 5, 0,  0, 0, 1, 0,  1, 5, 'h1234);
    row(0, 0, 0,       0, 0, 0,        0, 5, 0,  0, 0, 0, 0,  0, 5, 'h1234);
    row(0, 0, 0,       1, 0, 'hFFFF,   0, 0, 0,  0, 1, 0, 0,  0, 5, 'h1234);
    row(1, 1, 'hA1,    1, 9, 'hB9,     0, 0, 9,  1, 0, 0, 1,  0, 0, 'hFFFF);
    row(1, 2, 'hA2,    1, 9, 'hB9,     0, 0, 0,  0, 1, 0, 0,  1, 1, 'hA1);
    row(1, 2, 'hA2,    1, 10, 'hBA,    0, 0, 0,  1, 0, 0, 0,  1, 9, 'hB9);
    row(1, 3, 'hA3,    1, 10, 'hBA,    0, 0, 0,  0, 1, 0, 0,  1, 2, 'hA2);
    row(1, 3, 'hA3,    1, 11, 'hBB,    0, 0, 0,  1, 0, 0, 0,  1, 10, 'hBA);
    row(0, 0, 0,       1, 11, 'hBB,    0, 0, 0,  0, 1, 0, 0,  1, 3, 'hA3);
    row(0, 0, 0,       0, 0, 0,        0, 7, 0,  0, 0, 0, 0,  1, 11, 'hBB);
    row(1, 7, 'h11,    1, 7, 'h22,     0, 7, 0,  1, 0, 1, 0,  0, 11, 'hBB);
    row(0, 0, 0,       1, 7, 'h22,     0, 7, 0,  0, 1, 1, 0,  1, 7, 'h11);
    row(0, 0, 0,       0, 0, 0,        0, 7, 0,  0, 0, 1, 0,  1, 7, 'h22);
    row(1, 8, 'h88,    0, 0, 0,        0, 0, 0,  1, 0, 0, 0,  0, 7, 'h22);
    row(1, 12, 'hC,    1, 13, 'hD,     1, 0, 0,  0, 0, 0, 0,  1, 8, 'h88);
    row(1, 12, 'hC,    1, 13, 'hD,     1, 0, 0,  0, 0, 0, 0,  0, 8, 'h88);
    row(1, 12, 'hC,    1, 13, 'hD,     0, 0, 0,  0, 1, 0, 0,  0, 8, 'h88);
    row(1, 12, 'hC,    0, 0, 0,        0, 0, 0,  1, 0, 0, 0,  1, 13, 'hD);
    row(0, 0, 0,       0, 0, 0,        0, 0, 0,  0, 0, 0, 0,  1, 12, 'hC);
    row(1, 4, 'h44,    0, 0, 0,        1, 4, 0,  0, 0, 1, 0,  0, 12, 'hC);
    row(1, 4, 'h44,    0, 0, 0,        0, 4, 0,  0, 1, 1, 0,  0, 12, 'hC);
    row(0, 0, 0,       0, 0, 0,        0, 4, 0,  0, 0, 1, 0,  0, 12, 'hC);
    row(0, 0, 0,       0, 0, 0,        0, 4, 0,  0, 0, 0, 0,  0, 12, 'hC);

    // Rows 22-24 above are placeholders overwritten below once prio after row 20 is known.
    tbl[22] = '{1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd0,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 32'hC};
    tbl[23] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd0,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h44};
    tbl[24] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 32'h44};

    for (int i = 0; i < tbl.size(); i++) begin
      string t;
      t = $sformatf("row%0d", i);
      bus.aValid = tbl[i].av;  bus.aAddr = tbl[i].aa;  bus.aData = tbl[i].ad;
      bus.bValid = tbl[i].bv;  bus.bAddr = tbl[i].ba;  bus.bData = tbl[i].bd;
      bus.wbHold = tbl[i].hold;  bus.rAddr1 = tbl[i].r1;  bus.rAddr2 = tbl[i].r2;
      @(negedge clk);
      chk({t, ".aReady"}, 32'(bus.aReady), 32'(tbl[i].ea));
      chk({t, ".bReady"}, 32'(bus.bReady), 32'(tbl[i].eb));
      chk({t, ".hazard1"}, 32'(bus.hazard1), 32'(tbl[i].eh1));
      chk({t, ".hazard2"}, 32'(bus.hazard2), 32'(tbl[i].eh2));
      chk({t, ".wEna"}, 32'(bus.wEna), 32'(tbl[i].ewe));
      chk({t, ".wAddr"}, 32'(bus.wAddr), 32'(tbl[i].ewa));
      chk({t, ".wDin"}, bus.wDin, tbl[i].ewd);
      advance();
    end
    chk("r7_last_write", dut_rf[7], 32'h22);
    chk("r0_never_written", dut_rf[0], 32'h0);

    // Randomized traffic; a source keeps its request until the model says it was taken.
    drive_idle();
    for (int c = 0; c < 400; c++) begin
      if (!bus.aValid) begin
        bus.aValid = 1'($urandom_range(0, 1));
        bus.aAddr  = 5'($urandom_range(0, 7));
        bus.aData  = $urandom;
      end
      if (!bus.bValid) begin
        bus.bValid = 1'($urandom_range(0, 1));
        bus.bAddr  = 5'($urandom_range(0, 7));
        bus.bData  = $urandom;
      end
      bus.wbHold = 1'($urandom_range(0, 7) == 0);
      bus.rAddr1 = 5'($urandom_range(0, 7));
      bus.rAddr2 = 5'($urandom_range(0, 7));
      @(negedge clk);
      chk("rand.one_hot", 32'(bus.aReady & bus.bReady), 32'd0);
      check_model("rand");
      advance();
      if (last_w == 0) bus.aValid = 1'b0;
      if (last_w == 1) bus.bValid = 1'b0;
    end

    // Asynchronous reset while a write sits on the port, with the pointer on B.
    drive_idle();
    bus.aValid = 1'b1;  bus.aAddr = 5'd6;  bus.aData = 32'h66;
    @(negedge clk);
    check_model("pre_rst");
    advance();
    bus.aAddr = 5'd14;  bus.aData = 32'hAE;
    bus.bValid = 1'b1;  bus.bAddr = 5'd15;  bus.bData = 32'hBF;
    @(negedge clk);
    chk("rst_mid.wEna_before", 32'(bus.wEna), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.wEna", 32'(bus.wEna), 32'd0);
    chk("rst_mid.wAddr", 32'(bus.wAddr), 32'd0);
    chk("rst_mid.aReady", 32'(bus.aReady), 32'd0);
    chk("rst_mid.bReady", 32'(bus.bReady), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_mid.prio_a", 32'(bus.aReady), 32'd1);
    chk("rst_mid.prio_b", 32'(bus.bReady), 32'd0);
    advance();
    bus.aValid = 1'b0;
    @(negedge clk);
    check_model("post_rst");
    advance();
    bus.bValid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_model("drain");
      advance();
    end

    bad = 0;
    for (int i = 0; i < 32; i++) if (dut_rf[i] !== mdl_rf[i]) bad++;
    chk("regfile_contents", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
